// File: rtl/traffic_light_pkg.sv
// Shared state encodings, lamp patterns and helpers for the two-road intersection controller.
package traffic_light_pkg;

    localparam logic [2:0] ST_MG = 3'd0;
    localparam logic [2:0] ST_MY = 3'd1;
    localparam logic [2:0] ST_RS = 3'd2;
    localparam logic [2:0] ST_SG = 3'd3;
    localparam logic [2:0] ST_SY = 3'd4;
    localparam logic [2:0] ST_RM = 3'd5;
    localparam logic [2:0] ST_FL = 3'd6;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/traffic_light_phase_timer.sv
// Saturating down-counter used for phase durations and for the flash blink half-period.
module phase_timer #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Load has precedence over reset so the owner can preset the count while resetting.
    always_ff @(posedge clk) begin
        if (load) begin
            cnt_r <= load_val;
        end else if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r != {CNT_W{1'b0}}) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/traffic_light_intersection.sv
// Main/side intersection controller with demand-driven side service and maintenance flash.
// Optional pedestrian WALK support is enabled by defining TRAFFIC_PED_WALK_EN.
module traffic_light_intersection
    import traffic_light_pkg::*;
#(
    parameter int MAIN_MIN_CYC = 20,
    parameter int YEL_CYC      = 4,
    parameter int ALLRED_CYC   = 2,
    parameter int SIDE_GRN_CYC = 10,
    parameter int FLASH_HALF   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       side_req,
    input  logic       flash_en,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [2:0] phase
`ifdef TRAFFIC_PED_WALK_EN
    ,
    input  logic       ped_req,
    output logic       walk
`endif
);

    localparam int CNT_W = $clog2(max2(max2(max2(MAIN_MIN_CYC, YEL_CYC), max2(ALLRED_CYC, SIDE_GRN_CYC)),
                                       FLASH_HALF)) + 1;

    logic [2:0]       state_r;
    logic [2:0]       nxt_state_s;
    logic             req_pend_r;
    logic             blink_r;
    logic             blink_nxt_s;
    logic             blink_load_s;
    logic             blink_zero_s;
    logic             tmr_load_s;
    logic [CNT_W-1:0] tmr_val_s;
    logic             tmr_zero_s;
    logic             demand_s;
    logic             enter_sg_s;
    logic [2:0]       main_nxt_s;
    logic [2:0]       side_nxt_s;

    phase_timer #(.CNT_W(CNT_W)) u_phase_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .zero     (tmr_zero_s)
    );

    phase_timer #(.CNT_W(CNT_W)) u_blink_tmr (
        .clk      (clk),
        .reset    (reset),
        .load     (blink_load_s),
        .load_val (CNT_W'(FLASH_HALF - 1)),
        .zero     (blink_zero_s)
    );

`ifdef TRAFFIC_PED_WALK_EN
    logic ped_pend_r;
    logic walk_nxt_s;
    assign demand_s = req_pend_r | side_req | ped_pend_r | ped_req;
`else
    assign demand_s = req_pend_r | side_req;
`endif

    // Next-state, timer reload and blink decisions; reset beats flash beats timed transitions.
    always_comb begin
        nxt_state_s  = state_r;
        tmr_load_s   = 1'b0;
        tmr_val_s    = CNT_W'(MAIN_MIN_CYC - 1);
        blink_load_s = 1'b0;
        blink_nxt_s  = blink_r;
        if (reset) begin
            nxt_state_s = ST_MG;
            tmr_load_s  = 1'b1;
            tmr_val_s   = CNT_W'(MAIN_MIN_CYC - 1);
            blink_nxt_s = 1'b1;
        end else if (flash_en) begin
            nxt_state_s = ST_FL;
            if (state_r != ST_FL) begin
                blink_load_s = 1'b1;
                blink_nxt_s  = 1'b1;
            end else if (blink_zero_s) begin
                blink_load_s = 1'b1;
                blink_nxt_s  = ~blink_r;
            end else begin
                blink_nxt_s  = blink_r;
            end
        end else begin
            case (state_r)
                ST_MG: if (tmr_zero_s && demand_s) begin
                    nxt_state_s = ST_MY; tmr_load_s = 1'b1; tmr_val_s = CNT_W'(YEL_CYC - 1);
                end else begin
                    nxt_state_s = ST_MG;
                end
                ST_MY: if (tmr_zero_s) begin
                    nxt_state_s = ST_RS; tmr_load_s = 1'b1; tmr_val_s = CNT_W'(ALLRED_CYC - 1);
                end else begin
                    nxt_state_s = ST_MY;
                end
                ST_RS: if (tmr_zero_s) begin
                    nxt_state_s = ST_SG; tmr_load_s = 1'b1; tmr_val_s = CNT_W'(SIDE_GRN_CYC - 1);
                end else begin
                    nxt_state_s = ST_RS;
                end
                ST_SG: if (tmr_zero_s) begin
                    nxt_state_s = ST_SY; tmr_load_s = 1'b1; tmr_val_s = CNT_W'(YEL_CYC - 1);
                end else begin
                    nxt_state_s = ST_SG;
                end
                ST_SY: if (tmr_zero_s) begin
                    nxt_state_s = ST_RM; tmr_load_s = 1'b1; tmr_val_s = CNT_W'(ALLRED_CYC - 1);
                end else begin
                    nxt_state_s = ST_SY;
                end
                ST_RM: if (tmr_zero_s) begin
                    nxt_state_s = ST_MG; tmr_load_s = 1'b1; tmr_val_s = CNT_W'(MAIN_MIN_CYC - 1);
                end else begin
                    nxt_state_s = ST_RM;
                end
                ST_FL: begin
                    nxt_state_s = ST_RM; tmr_load_s = 1'b1; tmr_val_s = CNT_W'(ALLRED_CYC - 1);
                end
                default: begin
                    nxt_state_s = ST_MG; tmr_load_s = 1'b1; tmr_val_s = CNT_W'(MAIN_MIN_CYC - 1);
                end
            endcase
        end
    end

    assign enter_sg_s = (nxt_state_s == ST_SG) && (state_r != ST_SG);

    // Lamp patterns derived from the upcoming state so lamps change on the same edge as the state.
    always_comb begin
        main_nxt_s = LAMP_RED;
        side_nxt_s = LAMP_RED;
        case (nxt_state_s)
            ST_MG:   begin main_nxt_s = LAMP_GRN; side_nxt_s = LAMP_RED; end
            ST_MY:   begin main_nxt_s = LAMP_YEL; side_nxt_s = LAMP_RED; end
            ST_SG:   begin main_nxt_s = LAMP_RED; side_nxt_s = LAMP_GRN; end
            ST_SY:   begin main_nxt_s = LAMP_RED; side_nxt_s = LAMP_YEL; end
            ST_FL:   begin
                main_nxt_s = blink_nxt_s ? LAMP_YEL : LAMP_OFF;
                side_nxt_s = blink_nxt_s ? LAMP_RED : LAMP_OFF;
            end
            default: begin main_nxt_s = LAMP_RED; side_nxt_s = LAMP_RED; end
        endcase
    end

    // State, blink phase and lamp registers.
    always_ff @(posedge clk) begin
        state_r    <= nxt_state_s;
        blink_r    <= blink_nxt_s;
        main_light <= main_nxt_s;
        side_light <= side_nxt_s;
    end

    // Side demand latch: armed outside SG, frozen in flash, consumed on SG entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_pend_r <= 1'b0;
        end else if (enter_sg_s) begin
            req_pend_r <= 1'b0;
        end else if (side_req && (state_r != ST_SG) && (state_r != ST_FL)) begin
            req_pend_r <= 1'b1;
        end else begin
            req_pend_r <= req_pend_r;
        end
    end

`ifdef TRAFFIC_PED_WALK_EN
    // WALK is granted for the whole side green only when a pedestrian was waiting at entry.
    always_comb begin
        walk_nxt_s = 1'b0;
        if (enter_sg_s) begin
            walk_nxt_s = ped_pend_r;
        end else if (nxt_state_s == ST_SG) begin
            walk_nxt_s = walk;
        end else begin
            walk_nxt_s = 1'b0;
        end
    end

    // Pedestrian latch mirrors the side demand latch.
    always_ff @(posedge clk) begin
        walk <= walk_nxt_s;
        if (reset) begin
            ped_pend_r <= 1'b0;
        end else if (enter_sg_s) begin
            ped_pend_r <= 1'b0;
        end else if (ped_req && (state_r != ST_SG) && (state_r != ST_FL)) begin
            ped_pend_r <= 1'b1;
        end else begin
            ped_pend_r <= ped_pend_r;
        end
    end
`endif

    assign phase = state_r;

endmodule
